// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and the EX/MEM pipeline-register payload.
package ex_mem_stage_pkg;

  localparam int unsigned BW_MUL     = 96;
  localparam int unsigned MUL_PART_W = 32;
  localparam int unsigned RA_W       = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [3:0]  ALU_MUL    = 4'd13;

  // Everything captured at the EX/MEM boundary.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     result;
    logic [BW_MUL-1:0]     halfResult;
    logic                  mul;
    logic [DATA_W-1:0]     busB;
    logic [RA_W-1:0]       rd;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  memtoReg;
  } exMemReg_t;

endpackage

// File: rtl/ex_mem_stage_mul_unit_b.sv
// mul_unit_b: finishes the low 32 bits of MUL from three 32-bit partial products.
//   halfResult in  BW_MUL      {p2=Ahi*Blo, p1=Alo*Bhi, p0=Alo*Blo}
//   prod       out MUL_PART_W  p0 + ((p1 + p2) << 16), mod 2^32
module mul_unit_b
  import ex_mem_stage_pkg::*;
(
  input  logic [BW_MUL-1:0]     halfResult,
  output logic [MUL_PART_W-1:0] prod
);

  logic [MUL_PART_W-1:0] p0;
  logic [MUL_PART_W-1:0] p1;
  logic [MUL_PART_W-1:0] p2;
  logic [MUL_PART_W-1:0] crossSum;

  assign p0 = halfResult[MUL_PART_W-1:0];
  assign p1 = halfResult[2*MUL_PART_W-1:MUL_PART_W];
  assign p2 = halfResult[3*MUL_PART_W-1:2*MUL_PART_W];

  // Carry out of the cross-term sum cannot reach the low word, so it is dropped.
  assign crossSum = p1 + p2;
  assign prod     = p0 + {crossSum[MUL_PART_W/2-1:0], (MUL_PART_W/2)'(0)};

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline boundary of the 5-stage MIPS32 core.
//   clk, rst (sync, active-high), stall, flush  : pipeline control
//   ex_*                                        : EX-stage result, MUL partials, store data, controls
//   mem_*                                       : registered MEM-stage values; mem_Result muxes in MUL product
//   fwd_en / fwd_data                           : EX->MEM forwarding path back to ID/EX
//   mul_count                                   : MUL instructions accepted into MEM (wraps)
module ex_mem_stage #(
  parameter int unsigned BW_MUL = ex_mem_stage_pkg::BW_MUL,
  parameter int unsigned RA_W   = ex_mem_stage_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_Result,
  input  logic [BW_MUL-1:0] ex_half_Result,
  input  logic              ex_Mul,
  input  logic [31:0]       ex_busB,
  input  logic [RA_W-1:0]   ex_Rd,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic              ex_MemtoReg,
  output logic              mem_valid,
  output logic [31:0]       mem_Result,
  output logic [31:0]       mem_busB,
  output logic [RA_W-1:0]   mem_Rd,
  output logic              mem_RegWrite,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              mem_MemtoReg,
  output logic              fwd_en,
  output logic [31:0]       fwd_data,
  output logic [31:0]       mul_count
);

  import ex_mem_stage_pkg::*;

  exMemReg_t        stageQ;
  exMemReg_t        stageD;
  logic [31:0]      mulCount;
  logic [31:0]      mulProd;
  logic             loadEn;

  assign loadEn = !flush && !stall;

  // Next payload on a load; controls are squashed when EX holds no instruction.
  always_comb begin
    stageD            = '0;
    stageD.valid      = ex_valid;
    stageD.result     = ex_Result;
    stageD.halfResult = ex_half_Result;
    stageD.busB       = ex_busB;
    stageD.rd         = ex_Rd;
    stageD.memtoReg   = ex_MemtoReg;
    stageD.mul        = ex_valid & ex_Mul;
    stageD.regWrite   = ex_valid & ex_RegWrite;
    stageD.memRead    = ex_valid & ex_MemRead;
    stageD.memWrite   = ex_valid & ex_MemWrite;
  end

  // Pipeline register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stageQ <= '0;
    end else if (!stall) begin
      stageQ <= stageD;
    end
  end

  // MUL counter: only advances on a real load, untouched by flush or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      mulCount <= '0;
    end else if (loadEn && ex_valid && ex_Mul) begin
      mulCount <= mulCount + 32'd1;
    end
  end

  mul_unit_b uMulUnitB (
    .halfResult (stageQ.halfResult),
    .prod       (mulProd)
  );

  assign mem_valid    = stageQ.valid;
  assign mem_Result   = stageQ.mul ? mulProd : stageQ.result;
  assign mem_busB     = stageQ.busB;
  assign mem_Rd       = stageQ.rd;
  assign mem_RegWrite = stageQ.valid & stageQ.regWrite;
  assign mem_MemRead  = stageQ.valid & stageQ.memRead;
  assign mem_MemWrite = stageQ.valid & stageQ.memWrite;
  assign mem_MemtoReg = stageQ.memtoReg;
  assign mul_count    = mulCount;

  // Loads are never forwarded from MEM; the hazard unit stalls load-use instead.
  assign fwd_en   = mem_valid & mem_RegWrite & (mem_Rd != '0) & ~mem_MemRead;
  assign fwd_data = mem_Result;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_Result;
  logic [95:0] ex_half_Result;
  logic        ex_Mul;
  logic [31:0] ex_busB;
  logic [4:0]  ex_Rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_MemtoReg;
  logic        mem_valid;
  logic [31:0] mem_Result;
  logic [31:0] mem_busB;
  logic [4:0]  mem_Rd;
  logic        mem_RegWrite;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic        mem_MemtoReg;
  logic        fwd_en;
  logic [31:0] fwd_data;
  logic [31:0] mul_count;

  int checks;
  int failures;

  ex_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_Result      (ex_Result),
    .ex_half_Result (ex_half_Result),
    .ex_Mul         (ex_Mul),
    .ex_busB        (ex_busB),
    .ex_Rd          (ex_Rd),
    .ex_RegWrite    (ex_RegWrite),
    .ex_MemRead     (ex_MemRead),
    .ex_MemWrite    (ex_MemWrite),
    .ex_MemtoReg    (ex_MemtoReg),
    .mem_valid      (mem_valid),
    .mem_Result     (mem_Result),
    .mem_busB       (mem_busB),
    .mem_Rd         (mem_Rd),
    .mem_RegWrite   (mem_RegWrite),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_MemtoReg   (mem_MemtoReg),
    .fwd_en         (fwd_en),
    .fwd_data       (fwd_data),
    .mul_count      (mul_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_Result = '0; ex_half_Result = '0; ex_Mul = 0; ex_busB = '0;
    ex_Rd = '0; ex_RegWrite = 0; ex_MemRead = 0; ex_MemWrite = 0; ex_MemtoReg = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1; stall = 0; flush = 0;
    idle();
    ex_valid = 1; ex_Result = 32'hFFFF_FFFF; ex_RegWrite = 1; ex_Rd = 5'd3; ex_Mul = 1;
    step();
    step();
    // Reset: everything zero even with a busy EX.
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_result", mem_Result, 32'd0);
    chk("rst_fwd_en", 32'(fwd_en), 32'd0);
    chk("rst_mul_count", mul_count, 32'd0);
    rst = 0;
    idle();
    step();
    chk("idle_valid", 32'(mem_valid), 32'd0);
    chk("idle_mul_count", mul_count, 32'd0);

    // MUL 0x00010003 * 0x00020005 -> low word 0x000B000F.
    ex_valid = 1; ex_Mul = 1; ex_Result = 32'hDEAD_BEEF; ex_Rd = 5'd8; ex_RegWrite = 1;
    ex_half_Result = {32'h5, 32'h6, 32'hF};
    step();
    chk("mul1_result", mem_Result, 32'h000B_000F);
    chk("mul1_fwd_en", 32'(fwd_en), 32'd1);
    chk("mul1_fwd_data", fwd_data, 32'h000B_000F);
    chk("mul1_rd", 32'(mem_Rd), 32'd8);
    chk("mul1_count", mul_count, 32'd1);

    // MUL 0xFFFFFFFF * 0xFFFFFFFF -> low word 1 (cross-sum carry discarded).
    ex_half_Result = {32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001};
    step();
    chk("mul2_result", mem_Result, 32'h0000_0001);
    chk("mul2_count", mul_count, 32'd2);

    // ADD then 3 stalled cycles with changing EX.
    ex_Mul = 0; ex_Result = 32'h1234; ex_Rd = 5'd9; ex_half_Result = {32'h1, 32'h1, 32'h1};
    step();
    chk("add_result", mem_Result, 32'h1234);
    chk("add_count", mul_count, 32'd2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_Result = 32'h5555_0000 + 32'(i); ex_Mul = 1; ex_Rd = 5'(i + 1);
      step();
      chk("stall_result", mem_Result, 32'h1234);
      chk("stall_rd", 32'(mem_Rd), 32'd9);
      chk("stall_count", mul_count, 32'd2);
    end

    // Flush beats stall with a valid SW in EX.
    flush = 1;
    ex_Mul = 0; ex_RegWrite = 0; ex_MemWrite = 1; ex_busB = 32'hCAFE; ex_Rd = 5'd4;
    step();
    chk("flush_valid", 32'(mem_valid), 32'd0);
    chk("flush_memwrite", 32'(mem_MemWrite), 32'd0);
    chk("flush_fwd_en", 32'(fwd_en), 32'd0);
    chk("flush_busB", mem_busB, 32'd0);
    chk("flush_count", mul_count, 32'd2);
    flush = 0; stall = 0;
    step();
    chk("sw_memwrite", 32'(mem_MemWrite), 32'd1);
    chk("sw_busB", mem_busB, 32'hCAFE);
    chk("sw_fwd_en", 32'(fwd_en), 32'd0);

    // LW to r5: no forwarding.
    idle();
    ex_valid = 1; ex_Rd = 5'd5; ex_RegWrite = 1; ex_MemRead = 1; ex_MemtoReg = 1;
    ex_Result = 32'h100;
    step();
    chk("lw_memread", 32'(mem_MemRead), 32'd1);
    chk("lw_memtoreg", 32'(mem_MemtoReg), 32'd1);
    chk("lw_fwd_en", 32'(fwd_en), 32'd0);

    // ADD to r0: no forwarding.
    idle();
    ex_valid = 1; ex_Rd = 5'd0; ex_RegWrite = 1; ex_Result = 32'h77;
    step();
    chk("r0_fwd_en", 32'(fwd_en), 32'd0);
    chk("r0_result", mem_Result, 32'h77);

    // Invalid EX with MUL/RegWrite set: controls squashed, count unchanged.
    ex_valid = 0; ex_Rd = 5'd7; ex_Mul = 1; ex_Result = 32'h99;
    ex_half_Result = {32'h5, 32'h6, 32'hF};
    step();
    chk("bubble_valid", 32'(mem_valid), 32'd0);
    chk("bubble_regwrite", 32'(mem_RegWrite), 32'd0);
    chk("bubble_fwd_en", 32'(fwd_en), 32'd0);
    chk("bubble_result", mem_Result, 32'h99);
    chk("bubble_count", mul_count, 32'd2);

    // mul_count wrap from 0xFFFFFFFF.
    idle();
    force dut.mulCount = 32'hFFFF_FFFF;
    #1;
    release dut.mulCount;
    #1;
    chk("preload_count", mul_count, 32'hFFFF_FFFF);
    ex_valid = 1; ex_Mul = 1; ex_RegWrite = 1; ex_Rd = 5'd2;
    ex_half_Result = {32'h0, 32'h0, 32'h2A};
    step();
    chk("wrap_count", mul_count, 32'd0);
    chk("wrap_result", mem_Result, 32'h2A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
